// File: rtl/tick_countdown_timer.sv
// BCD MM:SS countdown timer advanced by the divider's one-cycle tick; drives digits, running/done and an alarm pulse.
// Optional build macro TIMER_AUTO_RELOAD_EN: reload from preset at 00:00 and keep running instead of entering DONE.
module tick_countdown_timer #(
  parameter int unsigned ALARM_LEN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] min_nxt, sec_nxt;
  logic [DW-1:0] pre_min, pre_sec, pre_min_nxt, pre_sec_nxt;
  logic [DW-1:0] dec_min, dec_sec;
  logic          hit_zero;
  logic          alarm_pend;
  logic [CW-1:0] alarm_cnt, alarm_cnt_nxt;

  // Limit each BCD digit of a preset to its legal range.
  function automatic logic [DW-1:0] clamp_digits(input logic [DW-1:0] v, input logic [3:0] tens_max);
    logic [3:0] t, u;
    t = (v[7:4] > tens_max) ? tens_max : v[7:4];
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {t, u};
  endfunction

  // Two-digit BCD decrement with borrow from tens into units; caller guarantees v != 0.
  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
    else                return {v[7:4] - 4'd1, 4'd9};
  endfunction

  always_comb begin
    if (sec_bcd != 8'h00) begin
      dec_sec = bcd_dec(sec_bcd);
      dec_min = min_bcd;
    end else begin
      dec_sec = 8'h59;
      dec_min = bcd_dec(min_bcd);
    end
  end

  // Next-state, value and preset logic; command priority load > stop > start.
  always_comb begin
    state_nxt   = state;
    min_nxt     = min_bcd;
    sec_nxt     = sec_bcd;
    pre_min_nxt = pre_min;
    pre_sec_nxt = pre_sec;
    hit_zero    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          min_nxt     = clamp_digits(load_min, 4'd9);
          sec_nxt     = clamp_digits(load_sec, 4'd5);
          pre_min_nxt = clamp_digits(load_min, 4'd9);
          pre_sec_nxt = clamp_digits(load_sec, 4'd5);
        end else if (start && ({min_bcd, sec_bcd} != 16'h0000)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = PAUSE;
        end else if (tick) begin
          min_nxt = dec_min;
          sec_nxt = dec_sec;
          if ({dec_min, dec_sec} == 16'h0000) begin
            hit_zero = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
            min_nxt = pre_min;
            sec_nxt = pre_sec;
            if ({pre_min, pre_sec} == 16'h0000) state_nxt = IDLE;
`else
            state_nxt = DONE;
`endif
          end
        end
      end
      PAUSE: begin
        if (load) begin
          state_nxt   = IDLE;
          min_nxt     = clamp_digits(load_min, 4'd9);
          sec_nxt     = clamp_digits(load_sec, 4'd5);
          pre_min_nxt = clamp_digits(load_min, 4'd9);
          pre_sec_nxt = clamp_digits(load_sec, 4'd5);
        end else if (stop) begin
          state_nxt = IDLE;
          min_nxt   = pre_min;
          sec_nxt   = pre_sec;
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (load) begin
          state_nxt   = IDLE;
          min_nxt     = clamp_digits(load_min, 4'd9);
          sec_nxt     = clamp_digits(load_sec, 4'd5);
          pre_min_nxt = clamp_digits(load_min, 4'd9);
          pre_sec_nxt = clamp_digits(load_sec, 4'd5);
        end else if (stop) begin
          state_nxt = IDLE;
          min_nxt   = pre_min;
          sec_nxt   = pre_sec;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Alarm runs off its own counter so later commands cannot cut it short.
  always_comb begin
    alarm_cnt_nxt = alarm_cnt;
    if (alarm_pend)                alarm_cnt_nxt = CW'(ALARM_LEN);
    else if (alarm_cnt != CW'(0))  alarm_cnt_nxt = alarm_cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      min_bcd    <= '0;
      sec_bcd    <= '0;
      pre_min    <= '0;
      pre_sec    <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      alarm_pend <= 1'b0;
      alarm_cnt  <= '0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_nxt;
      min_bcd    <= min_nxt;
      sec_bcd    <= sec_nxt;
      pre_min    <= pre_min_nxt;
      pre_sec    <= pre_sec_nxt;
      running    <= (state_nxt == RUN);
      done       <= (state_nxt == DONE);
      alarm_pend <= hit_zero;
      alarm_cnt  <= alarm_cnt_nxt;
      alarm      <= (alarm_cnt_nxt != CW'(0));
    end
  end

endmodule
